// File: rtl/btb_pkg.sv
// Shared widths, entry layout and counter constants for the branch target buffer.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

package btb_pkg;

    localparam int PC_WIDTH_DEF  = `PC_WIDTH;
    localparam int ENTRIES_DEF   = 16;
    localparam int CNT_WIDTH_DEF = 2;

    function automatic int idx_width(input int entries);
        return $clog2(entries);
    endfunction

    // Word-aligned PCs: bits [1:0] are neither index nor tag.
    function automatic int tag_width(input int pc_width, input int entries);
        return pc_width - idx_width(entries) - 2;
    endfunction

    // Weakly taken: MSB set, all lower bits clear.
    function automatic int weak_taken(input int cnt_width);
        return 1 << (cnt_width - 1);
    endfunction

    localparam int TAG_WIDTH_DEF = tag_width(PC_WIDTH_DEF, ENTRIES_DEF);

    typedef struct packed {
        logic                     valid;
        logic [TAG_WIDTH_DEF-1:0] tag;
        logic [PC_WIDTH_DEF-1:0]  target;
        logic [CNT_WIDTH_DEF-1:0] cnt;
    } btb_entry_t;

endpackage

// File: rtl/btb_if.sv
// Fetch-lookup / execute-update bundle between the core and the branch target buffer.
interface btb_if
    import btb_pkg::*;
#(
    parameter int PC_WIDTH   = PC_WIDTH_DEF,
    parameter int PERF_WIDTH = 32
);
    logic [PC_WIDTH-1:0]   lookup_pc_i;
    logic                  pred_hit_o;
    logic                  pred_taken_o;
    logic [PC_WIDTH-1:0]   pred_npc_o;

    // upd_valid_i is a one-cycle strobe with no ready: the table always accepts,
    // and an update is consumed at the rising edge where upd_valid_i is high.
    logic                  upd_valid_i;
    logic [PC_WIDTH-1:0]   upd_pc_i;
    logic                  upd_is_cti_i;
    logic                  upd_taken_i;
    logic [PC_WIDTH-1:0]   upd_target_i;
    logic [PC_WIDTH-1:0]   upd_pred_npc_i;
    logic                  clear_i;

    logic                  mispredict_o;
    logic [PERF_WIDTH-1:0] perf_cti_o;
    logic [PERF_WIDTH-1:0] perf_mispred_o;

    modport master (
        output lookup_pc_i, upd_valid_i, upd_pc_i, upd_is_cti_i, upd_taken_i,
               upd_target_i, upd_pred_npc_i, clear_i,
        input  pred_hit_o, pred_taken_o, pred_npc_o, mispredict_o,
               perf_cti_o, perf_mispred_o
    );

    modport slave (
        input  lookup_pc_i, upd_valid_i, upd_pc_i, upd_is_cti_i, upd_taken_i,
               upd_target_i, upd_pred_npc_i, clear_i,
        output pred_hit_o, pred_taken_o, pred_npc_o, mispredict_o,
               perf_cti_o, perf_mispred_o
    );
endinterface

// File: rtl/btb_sat_counter.sv
// Saturating up/down direction counter next-value logic.
module btb_sat_counter #(
    parameter int CNT_WIDTH = 2
) (
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic                 inc_i,
    input  logic                 dec_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (inc_i && !(&cnt_i)) begin
            cnt_o = cnt_i + CNT_WIDTH'(1);
        end else if (dec_i && (|cnt_i)) begin
            cnt_o = cnt_i - CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped tagged BTB with per-entry saturating direction counters and
// mispredict performance counters; combinational lookup, one update per cycle.
module btb_predictor
    import btb_pkg::*;
#(
    parameter int PC_WIDTH   = PC_WIDTH_DEF,
    parameter int ENTRIES    = ENTRIES_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int PERF_WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    btb_if.slave bus
);

    localparam int IDX  = idx_width(ENTRIES);
    localparam int TAGW = tag_width(PC_WIDTH, ENTRIES);
    localparam logic [CNT_WIDTH-1:0] CNT_WEAK = CNT_WIDTH'(weak_taken(CNT_WIDTH));

    typedef struct packed {
        logic                 valid;
        logic [TAGW-1:0]      tag;
        logic [PC_WIDTH-1:0]  target;
        logic [CNT_WIDTH-1:0] cnt;
    } entry_t;

    entry_t tbl_q [ENTRIES];
    entry_t tbl_d [ENTRIES];

    logic [PERF_WIDTH-1:0] perf_cti_q, perf_cti_d;
    logic [PERF_WIDTH-1:0] perf_mis_q, perf_mis_d;

    // Lookup reads registered state only, so a same-cycle update is never bypassed.
    logic [IDX-1:0]      lk_idx;
    logic [TAGW-1:0]     lk_tag;
    entry_t              lk_e;
    logic                lk_hit;
    logic                lk_taken;

    assign lk_idx   = bus.lookup_pc_i[IDX+1:2];
    assign lk_tag   = bus.lookup_pc_i[PC_WIDTH-1:IDX+2];
    assign lk_e     = tbl_q[lk_idx];
    assign lk_hit   = lk_e.valid && (lk_e.tag == lk_tag);
    assign lk_taken = lk_hit && lk_e.cnt[CNT_WIDTH-1];

    assign bus.pred_hit_o   = lk_hit;
    assign bus.pred_taken_o = lk_taken;
    assign bus.pred_npc_o   = lk_taken ? lk_e.target : bus.lookup_pc_i + PC_WIDTH'(4);

    logic [IDX-1:0]       up_idx;
    logic [TAGW-1:0]      up_tag;
    entry_t               up_e;
    logic                 up_hit;
    logic                 up_train;
    logic [CNT_WIDTH-1:0] up_cnt_next;
    logic [PC_WIDTH-1:0]  actual_npc;
    logic                 mispredict;

    assign up_idx     = bus.upd_pc_i[IDX+1:2];
    assign up_tag     = bus.upd_pc_i[PC_WIDTH-1:IDX+2];
    assign up_e       = tbl_q[up_idx];
    assign up_hit     = up_e.valid && (up_e.tag == up_tag);
    assign up_train   = bus.upd_valid_i && bus.upd_is_cti_i;
    assign actual_npc = bus.upd_taken_i ? bus.upd_target_i : bus.upd_pc_i + PC_WIDTH'(4);
    assign mispredict = bus.upd_valid_i && (actual_npc != bus.upd_pred_npc_i);

    assign bus.mispredict_o = mispredict;

    btb_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_sat_counter (
        .cnt_i (up_e.cnt),
        .inc_i (bus.upd_taken_i),
        .dec_i (!bus.upd_taken_i),
        .cnt_o (up_cnt_next)
    );

    always_comb begin
        tbl_d = tbl_q;
        if (bus.clear_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_d[i].valid = 1'b0;
            end
        end else if (up_train) begin
            if (up_hit) begin
                tbl_d[up_idx].cnt = up_cnt_next;
                if (bus.upd_taken_i) begin
                    tbl_d[up_idx].target = bus.upd_target_i;
                end
            end else if (bus.upd_taken_i) begin
                tbl_d[up_idx].valid  = 1'b1;
                tbl_d[up_idx].tag    = up_tag;
                tbl_d[up_idx].target = bus.upd_target_i;
                tbl_d[up_idx].cnt    = CNT_WEAK;
            end
        end
    end

    always_comb begin
        perf_cti_d = perf_cti_q;
        perf_mis_d = perf_mis_q;
        if (up_train) begin
            perf_cti_d = perf_cti_q + PERF_WIDTH'(1);
        end
        if (mispredict) begin
            perf_mis_d = perf_mis_q + PERF_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i] <= '0;
            end
            perf_cti_q <= '0;
            perf_mis_q <= '0;
        end else begin
            tbl_q      <= tbl_d;
            perf_cti_q <= perf_cti_d;
            perf_mis_q <= perf_mis_d;
        end
    end

    assign bus.perf_cti_o     = perf_cti_q;
    assign bus.perf_mispred_o = perf_mis_q;

endmodule

// File: tb/tb_btb_predictor.sv
// Randomized and directed bench for btb_predictor against an array-based reference model.
module tb_btb_predictor;

    localparam int NE = 16;

    logic clk;
    logic rst;

    btb_if #(.PC_WIDTH(32), .PERF_WIDTH(32)) bus ();

    btb_predictor #(
        .PC_WIDTH   (32),
        .ENTRIES    (NE),
        .CNT_WIDTH  (2),
        .PERF_WIDTH (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_valid [NE];
    logic [31:0] m_tag   [NE];
    logic [31:0] m_tgt   [NE];
    int          m_cnt   [NE];
    logic [31:0] m_perf_cti;
    logic [31:0] m_perf_mis;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % NE);
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] pc);
        return pc / (4 * NE);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_cnt[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_npc(input logic [31:0] pc);
        return m_taken(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_mispred();
        logic [31:0] actual;
        actual = bus.upd_taken_i ? bus.upd_target_i : bus.upd_pc_i + 32'd4;
        return bus.upd_valid_i && (actual != bus.upd_pred_npc_i);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 0;
            m_cnt[i]   = 0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
        end
        m_perf_cti = '0;
        m_perf_mis = '0;
    endtask

    // Applies this edge's inputs to the model (called right after the edge).
    task automatic m_commit();
        int i;
        if (rst) begin
            m_reset();
            return;
        end
        if (bus.upd_valid_i && bus.upd_is_cti_i) m_perf_cti = m_perf_cti + 32'd1;
        if (m_mispred()) m_perf_mis = m_perf_mis + 32'd1;
        i = m_idx(bus.upd_pc_i);
        if (bus.clear_i) begin
            for (int k = 0; k < NE; k++) m_valid[k] = 0;
        end else if (bus.upd_valid_i && bus.upd_is_cti_i) begin
            if (m_hit(bus.upd_pc_i)) begin
                if (bus.upd_taken_i) begin
                    m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
                    m_tgt[i] = bus.upd_target_i;
                end else begin
                    m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
                end
            end else if (bus.upd_taken_i) begin
                m_valid[i] = 1;
                m_tag[i]   = m_tagof(bus.upd_pc_i);
                m_tgt[i]   = bus.upd_target_i;
                m_cnt[i]   = 2;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.upd_valid_i    = 1'b0;
        bus.upd_pc_i       = '0;
        bus.upd_is_cti_i   = 1'b0;
        bus.upd_taken_i    = 1'b0;
        bus.upd_target_i   = '0;
        bus.upd_pred_npc_i = 32'd4;
        bus.clear_i        = 1'b0;
    endtask

    task automatic drive_upd(input logic [31:0] pc, input bit cti, input bit taken,
                             input logic [31:0] target, input logic [31:0] pred_npc);
        bus.upd_valid_i    = 1'b1;
        bus.upd_pc_i       = pc;
        bus.upd_is_cti_i   = cti;
        bus.upd_taken_i    = taken;
        bus.upd_target_i   = target;
        bus.upd_pred_npc_i = pred_npc;
    endtask

    // One clock: compare combinational outputs mid-cycle, then advance model.
    task automatic cycle();
        logic [31:0] pc;
        pc = bus.lookup_pc_i;
        exp_q.push_back({31'd0, m_mispred()});
        @(negedge clk);
        check("hit",       {31'd0, bus.pred_hit_o},   {31'd0, m_hit(pc)});
        check("taken",     {31'd0, bus.pred_taken_o}, {31'd0, m_taken(pc)});
        check("npc",       bus.pred_npc_o,            m_npc(pc));
        check("mispred",   {31'd0, bus.mispredict_o}, exp_q.pop_front());
        check("perf_cti",  bus.perf_cti_o,            m_perf_cti);
        check("perf_mis",  bus.perf_mispred_o,        m_perf_mis);
        @(posedge clk);
        m_commit();
        #1;
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input bit taken, input logic [31:0] target);
        bus.lookup_pc_i = pc;
        drive_upd(pc, 1'b1, taken, target, m_npc(pc));
        cycle();
    endtask

    task automatic look(input logic [31:0] pc);
        bus.lookup_pc_i = pc;
        cycle();
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        if ($urandom_range(0, 31) == 0) p = 32'hFFFF_FFFC;
        else p = 32'h8000_0000 + ($urandom_range(0, 63) * 4);
        return p;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] pc;
        rst = 1'b1;
        bus.lookup_pc_i = 32'h8000_0010;
        idle_inputs();
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state and first allocation
        look(32'h8000_0010);
        check("rst_npc", bus.pred_npc_o, 32'h8000_0014);
        bus.lookup_pc_i = 32'h8000_0010;
        drive_upd(32'h8000_0010, 1'b1, 1'b1, 32'h8000_0040, 32'h8000_0014);
        cycle();
        look(32'h8000_0010);

        // counter walk: down to 0, up to saturation, then back down
        train(32'h8000_0010, 1'b0, 32'h0);
        look(32'h8000_0010);
        train(32'h8000_0010, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) train(32'h8000_0010, 1'b1, 32'h8000_0080);
        train(32'h8000_0010, 1'b0, 32'h0);
        look(32'h8000_0010);
        train(32'h8000_0010, 1'b0, 32'h0);
        look(32'h8000_0010);

        // alias at the same index evicts the old tag
        train(32'h8000_0010, 1'b1, 32'h8000_0040);
        train(32'h8000_0050, 1'b1, 32'h8000_0100);
        look(32'h8000_0010);
        look(32'h8000_0050);

        // non-CTI with a stale taken prediction, never writes the table
        bus.lookup_pc_i = 32'h8000_0050;
        drive_upd(32'h8000_0050, 1'b0, 1'b0, 32'h0, 32'h8000_0100);
        cycle();
        look(32'h8000_0050);

        // clear wins over a same-cycle allocation
        bus.lookup_pc_i = 32'h8000_0090;
        drive_upd(32'h8000_0090, 1'b1, 1'b1, 32'h8000_0200, 32'h8000_0094);
        bus.clear_i = 1'b1;
        cycle();
        look(32'h8000_0090);
        look(32'h8000_0050);

        // randomized training with occasional clear and mid-stream reset
        for (int n = 0; n < 400; n++) begin
            pc = rand_pc();
            bus.lookup_pc_i = ($urandom_range(0, 1) == 1) ? pc : rand_pc();
            if ($urandom_range(0, 3) != 0) begin
                drive_upd(pc, $urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0,
                          32'h8000_0000 + ($urandom_range(0, 255) * 4),
                          ($urandom_range(0, 4) == 0) ? $urandom() : m_npc(pc));
            end
            bus.clear_i = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end

        // reset after training wipes everything
        for (int k = 0; k < 8; k++) train(32'h8000_0000 + k * 4, 1'b1, 32'h8000_0300);
        rst = 1'b1;
        bus.lookup_pc_i = 32'h8000_0000;
        drive_upd(32'h8000_0020, 1'b1, 1'b1, 32'h8000_0400, 32'h8000_0024);
        cycle();
        for (int k = 0; k < 9; k++) look(32'h8000_0000 + k * 4);
        check("post_rst_cti", bus.perf_cti_o, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
